// File: rtl/regfile_sb_if.sv
// Register file bus: writeback ports, scoreboard claim, decode reads and
// clear-engine control grouped behind one interface.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              ena;
  logic              wa_en;
  logic [ADDR_W-1:0] wa_addr;
  logic [DATA_W-1:0] wa_data;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              claim_en;
  logic [ADDR_W-1:0] claim_addr;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              rs_pend;
  logic              rt_pend;
  logic              clr_req;
  logic              clr_busy;

  modport master (
    output ena, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           claim_en, claim_addr, rs_addr, rt_addr, clr_req,
    input  rs_data, rt_data, rs_pend, rt_pend, clr_busy
  );

  modport slave (
    input  ena, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           claim_en, claim_addr, rs_addr, rt_addr, clr_req,
    output rs_data, rt_data, rs_pend, rt_pend, clr_busy
  );
endinterface

// File: rtl/regfile_sb.sv
// General-purpose register file: two write ports, pending scoreboard,
// write-through read bypass and a one-register-per-cycle clear engine.

// One decode read port: r0 masking, same-cycle bypass and pending merge.
module regfile_sb_rd #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic              ena,
  input  logic              clearing,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  input  logic [DATA_W-1:0] arr_data,
  input  logic              arr_pend,
  output logic [DATA_W-1:0] data,
  output logic              pend
);
  logic wa_hit, wb_hit, cl_hit;

  assign wa_hit = wa_en    && (wa_addr    == addr);
  assign wb_hit = wb_en    && (wb_addr    == addr);
  assign cl_hit = claim_en && (claim_addr == addr);

  // Priority: disabled, r0, clear-in-progress (raw array), port A, port B, array.
  always_comb begin
    data = '0;
    pend = 1'b0;
    if (!ena || (R0_ZERO && addr == '0)) begin
      data = '0;
      pend = 1'b0;
    end else if (clearing) begin
      data = arr_data;
      pend = arr_pend;
    end else begin
      if (wa_hit)      data = wa_data;
      else if (wb_hit) data = wb_data;
      else             data = arr_data;
      pend = (arr_pend && !wb_hit) || cl_hit;
    end
  end
endmodule

module regfile_sb #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter bit R0_ZERO = 1'b1
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NRD   = 2;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] idx, idx_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;

  logic idle_en, wa_ok, wb_ok, cl_ok, clearing;

  assign clearing = (state == CLEAR);
  assign idle_en  = bus.ena && (state == IDLE);
  // r0 writes and claims vanish when r0 is hardwired.
  assign wa_ok = idle_en && bus.wa_en    && !(R0_ZERO && bus.wa_addr    == '0);
  assign wb_ok = idle_en && bus.wb_en    && !(R0_ZERO && bus.wb_addr    == '0);
  assign cl_ok = idle_en && bus.claim_en && !(R0_ZERO && bus.claim_addr == '0);

  // Clear FSM state and index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // Clear FSM next state: walk every index once; ena low stalls the walk.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      IDLE:  if (bus.ena && bus.clr_req) state_nx = CLEAR;
      CLEAR: if (bus.ena) begin
        if (idx == ADDR_W'(DEPTH - 1)) begin
          state_nx = IDLE;
          idx_nx   = '0;
        end else begin
          idx_nx = idx + ADDR_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = '0;
      end
    endcase
  end

  // Register array: clear engine owns it while busy; port A is applied last so it wins collisions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.ena) begin
      if (clearing) begin
        mem[idx] <= '0;
      end else begin
        if (wb_ok) mem[bus.wb_addr] <= bus.wb_data;
        if (wa_ok) mem[bus.wa_addr] <= bus.wa_data;
      end
    end
  end

  // Scoreboard: port B retires, claim applied last so a same-cycle claim wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else if (bus.ena) begin
      if (clearing) begin
        pend[idx] <= 1'b0;
      end else begin
        if (wb_ok) pend[bus.wb_addr]    <= 1'b0;
        if (cl_ok) pend[bus.claim_addr] <= 1'b1;
      end
    end
  end

  logic [NRD-1:0][ADDR_W-1:0] rd_addr;
  logic [NRD-1:0][DATA_W-1:0] rd_data;
  logic [NRD-1:0]             rd_pend;

  assign rd_addr = {bus.rt_addr, bus.rs_addr};

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    regfile_sb_rd #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .R0_ZERO(R0_ZERO)
    ) u_rd (
      .ena       (bus.ena),
      .clearing  (clearing),
      .addr      (rd_addr[g]),
      .wa_en     (bus.wa_en),
      .wa_addr   (bus.wa_addr),
      .wa_data   (bus.wa_data),
      .wb_en     (bus.wb_en),
      .wb_addr   (bus.wb_addr),
      .wb_data   (bus.wb_data),
      .claim_en  (bus.claim_en),
      .claim_addr(bus.claim_addr),
      .arr_data  (mem[rd_addr[g]]),
      .arr_pend  (pend[rd_addr[g]]),
      .data      (rd_data[g]),
      .pend      (rd_pend[g])
    );
  end

  assign bus.rs_data  = rd_data[0];
  assign bus.rt_data  = rd_data[1];
  assign bus.rs_pend  = rd_pend[0];
  assign bus.rt_pend  = rd_pend[1];
  assign bus.clr_busy = clearing;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset, bypass, scoreboard, clear engine,
// clear stalls/reset and block enable.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .R0_ZERO(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ena = 1'b1;
    bus.wa_en = 1'b0; bus.wa_addr = '0; bus.wa_data = '0;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.claim_en = 1'b0; bus.claim_addr = '0;
    bus.clr_req = 1'b0;
  endtask

  task automatic wr_a(input logic [4:0] a, input logic [31:0] d);
    bus.wa_en = 1'b1; bus.wa_addr = a; bus.wa_data = d;
    tick();
    bus.wa_en = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    bus.rs_addr = 5'd5; bus.rt_addr = 5'd9;
    rst = 1'b1;
    tick(); tick();
    total++;
    if (bus.clr_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", bus.clr_busy); end
    total++;
    if (bus.rs_data !== 32'h0) begin bad++; $display("FAIL reset_rs got=%h want=0", bus.rs_data); end
    total++;
    if (bus.rt_pend !== 1'b0) begin bad++; $display("FAIL reset_pend got=%0b want=0", bus.rt_pend); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    wr_a(5'd5, 32'hDEADBEEF);
    bus.rs_addr = 5'd5; #1;
    total++;
    if (bus.rs_data !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_r5 got=%h want=deadbeef", bus.rs_data); end
    total++;
    if (bus.rs_pend !== 1'b0) begin bad++; $display("FAIL basic_r5_pend got=%0b want=0", bus.rs_pend); end
    bus.wa_en = 1'b1; bus.wa_addr = 5'd0; bus.wa_data = 32'h1234; bus.rs_addr = 5'd0; #1;
    total++;
    if (bus.rs_data !== 32'h0) begin bad++; $display("FAIL r0_bypass got=%h want=0", bus.rs_data); end
    tick();
    bus.wa_en = 1'b0; #1;
    total++;
    if (bus.rs_data !== 32'h0) begin bad++; $display("FAIL r0_write got=%h want=0", bus.rs_data); end
  endtask

  task automatic test_bypass();
    bus.wa_en = 1'b1; bus.wa_addr = 5'd7; bus.wa_data = 32'h11; bus.rs_addr = 5'd7; #1;
    total++;
    if (bus.rs_data !== 32'h11) begin bad++; $display("FAIL bypass_a got=%h want=11", bus.rs_data); end
    tick();
    bus.wa_data = 32'h22;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h33; #1;
    total++;
    if (bus.rs_data !== 32'h22) begin bad++; $display("FAIL bypass_ab got=%h want=22", bus.rs_data); end
    tick();
    bus.wa_en = 1'b0; bus.wb_en = 1'b0; #1;
    total++;
    if (bus.rs_data !== 32'h22) begin bad++; $display("FAIL collide_r7 got=%h want=22", bus.rs_data); end
    bus.wb_en = 1'b1; bus.wb_addr = 5'd8; bus.wb_data = 32'h44; bus.rt_addr = 5'd8; #1;
    total++;
    if (bus.rt_data !== 32'h44) begin bad++; $display("FAIL bypass_b got=%h want=44", bus.rt_data); end
    tick();
    bus.wb_en = 1'b0;
  endtask

  task automatic test_scoreboard();
    bus.rt_addr = 5'd9;
    bus.claim_en = 1'b1; bus.claim_addr = 5'd9; #1;
    total++;
    if (bus.rt_pend !== 1'b1) begin bad++; $display("FAIL claim_same got=%0b want=1", bus.rt_pend); end
    tick();
    bus.claim_en = 1'b0; #1;
    total++;
    if (bus.rt_pend !== 1'b1) begin bad++; $display("FAIL claim_next got=%0b want=1", bus.rt_pend); end
    bus.wb_en = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h55; #1;
    total++;
    if (bus.rt_pend !== 1'b0 || bus.rt_data !== 32'h55) begin
      bad++; $display("FAIL wb_retire got=%0b/%h want=0/55", bus.rt_pend, bus.rt_data);
    end
    tick();
    bus.wb_en = 1'b0; #1;
    total++;
    if (bus.rt_pend !== 1'b0) begin bad++; $display("FAIL retired got=%0b want=0", bus.rt_pend); end
    bus.claim_en = 1'b1; bus.wb_en = 1'b1; bus.wb_data = 32'h56;
    tick();
    bus.claim_en = 1'b0; bus.wb_en = 1'b0; #1;
    total++;
    if (bus.rt_pend !== 1'b1 || bus.rt_data !== 32'h56) begin
      bad++; $display("FAIL claim_wins got=%0b/%h want=1/56", bus.rt_pend, bus.rt_data);
    end
  endtask

  task automatic test_clear();
    int n;
    for (int r = 1; r < 32; r++) wr_a(5'(r), 32'h1000_0000 | r);
    bus.claim_en = 1'b1; bus.claim_addr = 5'd3;  tick();
    bus.claim_addr = 5'd31; tick();
    bus.claim_en = 1'b0;
    bus.clr_req = 1'b1; tick(); bus.clr_req = 1'b0;
    n = 0;
    while (bus.clr_busy && n < 100) begin
      n++;
      if (n == 20) begin
        bus.wa_en = 1'b1; bus.wa_addr = 5'd2; bus.wa_data = 32'hAAAA; bus.rs_addr = 5'd2; #1;
        total++;
        if (bus.rs_data !== 32'h0) begin bad++; $display("FAIL clear_nobypass got=%h want=0", bus.rs_data); end
      end else begin
        bus.wa_en = 1'b0;
      end
      tick();
    end
    bus.wa_en = 1'b0;
    total++;
    if (n !== 32) begin bad++; $display("FAIL clear_busy_len got=%0d want=32", n); end
    for (int r = 0; r < 32; r++) begin
      bus.rs_addr = 5'(r); bus.rt_addr = 5'(r); #1;
      total++;
      if (bus.rs_data !== 32'h0 || bus.rt_pend !== 1'b0) begin
        bad++; $display("FAIL cleared_r%0d got=%h/%0b want=0/0", r, bus.rs_data, bus.rt_pend);
      end
    end
  endtask

  task automatic test_clear_ena();
    int n;
    wr_a(5'd12, 32'hC0DE);
    bus.clr_req = 1'b1; tick(); bus.clr_req = 1'b0;
    n = 0;
    bus.rs_addr = 5'd12;
    while (bus.clr_busy && n < 100) begin
      n++;
      bus.ena = (n >= 10 && n <= 12) ? 1'b0 : 1'b1; #1;
      if (n == 11) begin
        total++;
        if (bus.rs_data !== 32'h0) begin bad++; $display("FAIL ena_low_read got=%h want=0", bus.rs_data); end
      end
      tick();
    end
    bus.ena = 1'b1;
    total++;
    if (n !== 35) begin bad++; $display("FAIL stall_busy_len got=%0d want=35", n); end
    #1;
    total++;
    if (bus.rs_data !== 32'h0) begin bad++; $display("FAIL stall_r12 got=%h want=0", bus.rs_data); end
  endtask

  task automatic test_clear_rst();
    wr_a(5'd20, 32'h2020);
    bus.claim_en = 1'b1; bus.claim_addr = 5'd21; tick(); bus.claim_en = 1'b0;
    bus.clr_req = 1'b1; tick(); bus.clr_req = 1'b0;
    repeat (5) tick();
    #2 rst = 1'b1; #1;
    bus.rs_addr = 5'd20; bus.rt_addr = 5'd21; #1;
    total++;
    if (bus.clr_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%0b want=0", bus.clr_busy); end
    total++;
    if (bus.rs_data !== 32'h0 || bus.rt_pend !== 1'b0) begin
      bad++; $display("FAIL rst_mid_state got=%h/%0b want=0/0", bus.rs_data, bus.rt_pend);
    end
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (bus.clr_busy !== 1'b0) begin bad++; $display("FAIL rst_after_busy got=%0b want=0", bus.clr_busy); end
  endtask

  task automatic test_ena();
    wr_a(5'd3, 32'h33);
    bus.ena = 1'b0;
    bus.wa_en = 1'b1; bus.wa_addr = 5'd3; bus.wa_data = 32'h77; bus.rs_addr = 5'd3; #1;
    total++;
    if (bus.rs_data !== 32'h0 || bus.rs_pend !== 1'b0) begin
      bad++; $display("FAIL ena_off_read got=%h/%0b want=0/0", bus.rs_data, bus.rs_pend);
    end
    tick();
    bus.wa_en = 1'b0; bus.ena = 1'b1; #1;
    total++;
    if (bus.rs_data !== 32'h33) begin bad++; $display("FAIL ena_off_write got=%h want=33", bus.rs_data); end
  endtask

  initial begin
    rst = 1'b0;
    bus.rs_addr = '0; bus.rt_addr = '0;
    idle();
    test_reset();
    test_basic();
    test_bypass();
    test_scoreboard();
    test_clear();
    test_clear_ena();
    test_clear_rst();
    test_ena();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
